// File: rtl/param_memory_pkg.sv
// Shared constants, FSM state type and parity helper for param_memory.
package param_memory_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 4;
  localparam int unsigned CNT_W   = 3;       // holds 0..LAT_MAX
  localparam int unsigned PAR_W   = STRB_W;  // one even-parity bit per byte

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Even parity per byte: each bit makes its byte plus itself XOR to zero.
  function automatic logic [PAR_W-1:0] byte_parity(input logic [DATA_W-1:0] d);
    logic [PAR_W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < PAR_W; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/param_memory_array.sv
// Byte-enabled word RAM with a READ_LATENCY-deep registered read pipeline.
// Optional per-byte parity storage under PARAM_MEMORY_PARITY_EN.
module param_memory_array
  import param_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 13,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [STRB_W-1:0]     wstrb_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  perr_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_W-1:0] mem_q     [DEPTH];
  logic [DATA_W-1:0] rd_pipe_q [READ_LATENCY];

  // Byte-lane writes.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (we_i && wstrb_i[i]) begin
        mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Read pipeline: stage 0 samples the array, later stages shift.
  always_ff @(posedge clk) begin
    rd_pipe_q[0] <= mem_q[raddr_i];
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  assign rdata_o = rd_pipe_q[READ_LATENCY-1];

`ifdef PARAM_MEMORY_PARITY_EN
  logic [PAR_W-1:0] par_q      [DEPTH];
  logic [PAR_W-1:0] par_pipe_q [READ_LATENCY];
  logic [PAR_W-1:0] wpar_c;

  assign wpar_c = byte_parity(wdata_i);

  // Parity bits follow their byte lanes.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < PAR_W; i++) begin
      if (we_i && wstrb_i[i]) begin
        par_q[waddr_i][i] <= wpar_c[i];
      end
    end
  end

  // Parity travels through the same pipeline depth as the data.
  always_ff @(posedge clk) begin
    par_pipe_q[0] <= par_q[raddr_i];
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      par_pipe_q[i] <= par_pipe_q[i-1];
    end
  end

  assign perr_o = |(par_pipe_q[READ_LATENCY-1] ^ byte_parity(rdata_o));
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/param_memory.sv
// param_memory: bus-mapped word memory with fixed-latency reads and a
// busy stall. Optional byte parity: define PARAM_MEMORY_PARITY_EN.
module param_memory
  import param_memory_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned ADDR_WIDTH   = 13,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rreq,
  input  logic              wreq,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ack,
  output logic              perr
);

  if (READ_LATENCY < LAT_MIN || READ_LATENCY > LAT_MAX) begin : g_bad_lat
    $error("param_memory: READ_LATENCY out of range");
  end

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADDR_WIDTH-1:0]   raddr_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    perr_q;

  logic [31:0]             offset_c;
  logic                    hit_c;
  logic [ADDR_WIDTH-1:0]   word_c;
  logic                    we_c;
  logic                    start_c;
  logic                    hold_c;
  logic                    done_c;
  logic [DATA_W-1:0]       arr_rdata;
  logic                    arr_perr;
  logic                    unused_c;

  // Window decode; subtraction wraps modulo 2^32 so addresses below the base miss.
  assign offset_c = addr - BASE_ADDR;
  assign hit_c    = (offset_c >> (ADDR_WIDTH + 2)) == 32'd0;
  assign word_c   = offset_c[ADDR_WIDTH+1:2];
  assign unused_c = ^offset_c[1:0];

  assign ack  = (rreq | wreq) & hit_c;
  assign we_c = reset & wreq & ack & ~rreq;

  // A pending read survives only while the master holds the same in-window word.
  assign start_c = (state_q == ST_IDLE) & rreq & ack;
  assign hold_c  = rreq & hit_c & (word_c == raddr_q);
  assign done_c  = (state_q == ST_WAIT) & hold_c & (cnt_q == CNT_W'(READ_LATENCY));

  assign busy  = start_c | ((state_q == ST_WAIT) & hold_c & ~done_c);
  assign rdata = done_c ? arr_rdata : rdata_q;
  assign perr  = done_c ? arr_perr  : perr_q;

  param_memory_array #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_array (
    .clk     (clk),
    .we_i    (we_c),
    .waddr_i (word_c),
    .wdata_i (wdata),
    .wstrb_i (wstrb),
    .raddr_i (word_c),
    .rdata_o (arr_rdata),
    .perr_o  (arr_perr)
  );

  // Read sequencer: count array latency, capture data on completion, abort on violation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            state_q <= ST_WAIT;
            cnt_q   <= CNT_W'(1);
            raddr_q <= word_c;
          end
        end
        ST_WAIT: begin
          if (!hold_c) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (done_c) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= arr_rdata;
            perr_q  <= arr_perr;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
